// File: rtl/csa16_seq_arb.sv
// csa16_seq_arb: two-requester round-robin sequencer that performs WORDS x 16-bit additions
// on one shared carry-select adder, least-significant slice first.

module csa16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;
    assign lo   = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
    assign hi0  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign hi1  = hi0 + 9'd1;
    assign s    = {lo[8] ? hi1[7:0] : hi0[7:0], lo[7:0]};
    assign cout = lo[8] ? hi1[8] : hi0[8];
endmodule

module csa16_seq_arb #(
    parameter int n     = 16,
    parameter int WORDS = 4,
    parameter int W     = n * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_s,
    output logic         rsp_cout,
    output logic         busy
);
    localparam int IW = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [W-1:0] a_r, b_r, s_r;
    logic [IW-1:0] idx;
    logic carry, id_r, cout_r, ptr;
    logic g0, g1, grant, last, co;
    logic [n-1:0] sum;

    csa16bits adder (
        .a(a_r[n*idx +: n]),
        .b(b_r[n*idx +: n]),
        .cin(carry),
        .s(sum),
        .cout(co)
    );

    // ptr names the requester that wins when both are valid
    assign g0    = req0_valid & (~req1_valid | ~ptr);
    assign g1    = req1_valid & (~req0_valid | ptr);
    assign grant = req0_ready | req1_ready;
    assign last  = idx == IW'(WORDS - 1);

    always_ff @(posedge clk) state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? ((req0_valid | req1_valid) ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              state == DONE ? (rsp_ready ? IDLE : DONE) : IDLE;
    end

    always_comb begin
        req0_ready = ~rst & (state == IDLE) & g0;
        req1_ready = ~rst & (state == IDLE) & g1;
        rsp_valid  = state == DONE;
        busy       = state != IDLE;
        rsp_id     = id_r;
        rsp_s      = s_r;
        rsp_cout   = cout_r;
    end

    // carry register takes cin at grant so slice 0 needs no special case
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            id_r   <= 1'b0;
            cout_r <= 1'b0;
            ptr    <= 1'b0;
        end else if (grant) begin
            a_r   <= g1 ? req1_a : req0_a;
            b_r   <= g1 ? req1_b : req0_b;
            carry <= g1 ? req1_cin : req0_cin;
            id_r  <= g1;
            idx   <= '0;
            ptr   <= ~g1;
        end else if (state == RUN) begin
            s_r[n*idx +: n] <= sum;
            carry           <= co;
            idx             <= idx + IW'(1);
            if (last) cout_r <= co;
        end
    end
endmodule

// File: tb/tb_csa16_seq_arb.sv
// tb_csa16_seq_arb: directed self-checking bench for csa16_seq_arb (WORDS=4).

module tb_csa16_seq_arb;
    localparam int N = 16, WORDS = 4, W = 64;
    logic clk = 0, rst = 1;
    logic req0_valid = 0, req0_cin = 0, req1_valid = 0, req1_cin = 0, rsp_ready = 0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_s;
    int checks = 0, failures = 0;

    csa16_seq_arb #(.n(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_s"}, rsp_s, 0);
        chk({tag, "_rsp_cout"}, rsp_cout, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        if (id) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_cin = c;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_cin = c;
        end
        #1;
        chk("grant_ready0", req0_ready, !id);
        chk("grant_ready1", req1_ready, id);
        tick;
        req0_valid = 0;
        req1_valid = 0;
        chk("busy_after_grant", busy, 1);
    endtask

    task automatic complete(input logic [W-1:0] es, input logic ec, input logic eid);
        for (int k = 0; k < WORDS; k++) begin
            chk("run_rsp_valid", rsp_valid, 0);
            chk("run_ready", {req0_ready, req1_ready}, 0);
            tick;
        end
        chk("done_rsp_valid", rsp_valid, 1);
        chk("done_rsp_s", rsp_s, es);
        chk("done_rsp_cout", rsp_cout, ec);
        chk("done_rsp_id", rsp_id, eid);
        chk("done_busy", busy, 1);
    endtask

    task automatic handshake;
        rsp_ready = 1;
        #1;
        chk("done_ready", {req0_ready, req1_ready}, 0);
        tick;
        rsp_ready = 0;
        chk("after_hs_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        rsp_ready = 1;
        tick;
        tick;
        chk_idle_outputs("reset");
        rsp_ready = 0;
        rst = 0;
        tick;
        chk("idle_busy", busy, 0);

        issue(0, 64'h0000_0000_0000_FFFF, 64'h1, 0);
        complete(64'h0000_0000_0001_0000, 0, 0);
        handshake;

        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        complete(64'h0, 1, 0);
        handshake;

        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        complete(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        handshake;

        // operands altered during RUN, with response stalled for 10 cycles while req1 waits
        issue(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0);
        req0_a = 64'h0;
        req0_b = 64'h5;
        req1_valid = 1;
        req1_a = 64'h0000_FFFF_0000_FFFF;
        req1_b = 64'h0000_0001_0000_0001;
        req1_cin = 0;
        complete(64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_s", rsp_s, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("stall_rsp_id", rsp_id, 0);
            chk("stall_ready1", req1_ready, 0);
            tick;
        end
        handshake;
        chk("post_stall_grant1", req1_ready, 1);
        tick;
        req1_valid = 0;
        complete(64'h0001_0000_0001_0000, 0, 1);
        handshake;

        // reset at slice 2 discards the operation
        issue(0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1);
        tick;
        tick;
        rst = 1;
        tick;
        rst = 0;
        chk_idle_outputs("midrun_reset");
        for (int k = 0; k < 6; k++) begin
            chk("midrun_no_rsp", {rsp_valid, busy}, 0);
            tick;
        end

        // pointer back at requester 0 after reset: order 0,1,0,1
        req0_valid = 1;
        req0_a = 64'h1111_2222_3333_4444;
        req0_b = 64'h0101_0101_0101_0101;
        req0_cin = 0;
        req1_valid = 1;
        req1_a = 64'h8000_0000_0000_0000;
        req1_b = 64'h8000_0000_0000_0001;
        req1_cin = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, i % 2 == 0);
            chk("rr_ready1", req1_ready, i % 2 == 1);
            tick;
            if (i % 2 == 0) complete(64'h1212_2323_3434_4545, 0, 0);
            else complete(64'h2, 1, 1);
            handshake;
        end
        req0_valid = 0;
        req1_valid = 0;
        tick;

        issue(1, 64'hDEAD_BEEF_0000_0001, 64'h2152_4111_FFFF_FFFF, 0);
        complete(64'h0000_0001_0000_0000, 1, 1);
        rsp_ready = 1;
        tick;
        rsp_ready = 1;
        #1;
        chk("rsp_ready_outside_done", {rsp_valid, busy}, 0);
        rsp_ready = 0;

        // reset wins over a simultaneous valid
        rst = 1;
        req0_valid = 1;
        #1;
        chk("rst_prio_ready", req0_ready, 0);
        tick;
        rst = 0;
        req0_valid = 0;
        chk("rst_prio_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
